// File: rtl/servant_apb_bridge.sv
// Wishbone classic to APB4 bridge for the servant external peripheral port.
// One transfer in flight; slave errors and hung slaves end in a defined completion.
module servant_apb_bridge #(
    parameter int          AW        = 32,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic [AW-1:0] o_paddr,
    output logic          o_psel,
    output logic          o_penable,
    output logic          o_pwrite,
    output logic [31:0]   o_pwdata,
    output logic [3:0]    o_pstrb,
    input  logic [31:0]   i_prdata,
    input  logic          i_pready,
    input  logic          i_pslverr,
    output logic          o_err,
    input  logic          i_err_clr
);

    localparam int          CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] TIMEOUT_U = TIMEOUT;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          err_set;

    // Abort on the TIMEOUT-th ACCESS cycle that still has no ready.
    assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !i_pready &&
                         ((32'(wait_cnt) + 32'd1) == TIMEOUT_U);
    assign err_set     = (state == ACCESS) && ((i_pready && i_pslverr) || timeout_hit);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_wb_cyc) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (i_pready || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // APB/Wishbone strobes are decoded from the next state so they leave a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_wb_ack  <= 1'b0;
        end else begin
            state     <= state_next;
            o_psel    <= (state_next == SETUP) || (state_next == ACCESS);
            o_penable <= (state_next == ACCESS);
            o_wb_ack  <= (state_next == DONE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_paddr  <= '0;
            o_pwdata <= '0;
            o_pstrb  <= '0;
            o_pwrite <= 1'b0;
            wait_cnt <= '0;
        end else if (state == IDLE && i_wb_cyc) begin
            o_paddr  <= i_wb_adr[AW-1:0];
            o_pwdata <= i_wb_dat;
            o_pstrb  <= i_wb_we ? i_wb_sel : 4'b0000;
            o_pwrite <= i_wb_we;
            wait_cnt <= '0;
        end else if (state == ACCESS && !i_pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Read data only changes when a read completes; writes leave it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_rdt <= '0;
        end else if (state == ACCESS && !o_pwrite) begin
            if (i_pready)
                o_wb_rdt <= i_pslverr ? ERR_RDATA : i_prdata;
            else if (timeout_hit)
                o_wb_rdt <= ERR_RDATA;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_err <= 1'b0;
        else if (err_set)
            o_err <= 1'b1;
        else if (i_err_clr)
            o_err <= 1'b0;
    end

endmodule
